mem_port_arbiter: RTL and testbench

//  Shares the single-ported main memory between the CPU control unit (fetch/operand/store)
//  and the debug/program-loader port. Grants one requester at a time, sequences the
//  one-cycle memory strobe and the read-latency wait, and returns data with a one-cycle ack.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between the CPU control unit and the debug/loader port.
// One transaction at a time: IDLE -> ISSUE -> WAIT x RD_LAT (reads only) -> DONE -> IDLE.
module mem_port_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic cpu_elig;
  logic dbg_elig;
  logic grant_dbg;

  assign cpu_elig  = cpu_req && !dbg_lock;
  assign dbg_elig  = dbg_req;
  // On a tie the requester that was not served last wins (last_q: 1 = debug).
  assign grant_dbg = dbg_elig && (!cpu_elig || !last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_elig || dbg_elig) begin
          owner_d = grant_dbg;
          we_d    = grant_dbg ? dbg_we    : cpu_we;
          addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CW'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_re    = (state_q == ISSUE) && !we_q;
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == DONE) && !owner_q;
  assign dbg_ack   = (state_q == DONE) && owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one RD_LAT=1 instance backed by a memory model,
// and one RD_LAT=3 instance fed by a delay-line read model for the latency check.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;

  logic        cpuReq, cpuWe, cpuAck, dbgReq, dbgWe, dbgLock, dbgAck;
  logic [11:0] cpuAddr, dbgAddr, memAddr;
  logic [15:0] cpuWdata, cpuRdata, dbgWdata, dbgRdata, memWdata, memRdata;
  logic        memRe, memWe, busy, owner;

  logic        cpuReq3, cpuAck3, dbgAck3, memRe3, memWe3, busy3, owner3;
  logic [11:0] cpuAddr3, memAddr3;
  logic [15:0] cpuRdata3, dbgRdata3, memWdata3, memRdata3;
  logic [15:0] pipe3 [0:2];

  logic [15:0] mem1 [0:4095];

  int assertCount = 0;
  int failCount   = 0;

  mem_port_arbiter #(.AW(12), .DW(16), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_ack(cpuAck), .cpu_rdata(cpuRdata),
    .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
    .dbg_lock(dbgLock), .dbg_ack(dbgAck), .dbg_rdata(dbgRdata),
    .mem_re(memRe), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(12), .DW(16), .RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .cpu_req(cpuReq3), .cpu_we(1'b0), .cpu_addr(cpuAddr3), .cpu_wdata(16'h0000),
    .cpu_ack(cpuAck3), .cpu_rdata(cpuRdata3),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(12'h000), .dbg_wdata(16'h0000),
    .dbg_lock(1'b0), .dbg_ack(dbgAck3), .dbg_rdata(dbgRdata3),
    .mem_re(memRe3), .mem_we(memWe3), .mem_addr(memAddr3), .mem_wdata(memWdata3),
    .mem_rdata(memRdata3), .busy(busy3), .owner(owner3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read data is only non-zero in the cycle(s) it is meant to be valid, so early or late capture shows up.
  always @(posedge clock) begin
    if (memWe) mem1[memAddr] <= memWdata;
    memRdata <= memRe ? mem1[memAddr] : 16'h0000;
    pipe3[0] <= memRe3 ? ({4'h0, memAddr3} ^ 16'h5A00) : 16'h0000;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign memRdata3 = pipe3[2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one transaction on the RD_LAT=1 instance with only one requester active.
  task automatic applyStimulus(input logic isDbg, input logic we, input logic [11:0] addr,
                               input logic [15:0] wdata, input logic [15:0] expRdata,
                               input int expLat, input string tag);
    int lat;
    int strobes;
    logic done;
    if (isDbg) begin
      dbgReq = 1'b1; dbgWe = we; dbgAddr = addr; dbgWdata = wdata;
    end else begin
      cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
    end
    lat = 0; strobes = 0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      checkOutput({tag, "_otherAck"}, isDbg ? cpuAck : dbgAck, 0);
      if (memRe || memWe) begin
        strobes++;
        checkOutput({tag, "_strobeWe"}, memWe, we);
        checkOutput({tag, "_addr"}, memAddr, addr);
        if (we) checkOutput({tag, "_wdata"}, memWdata, wdata);
      end
      if (busy) checkOutput({tag, "_owner"}, owner, isDbg);
      if (isDbg ? dbgAck : cpuAck) done = 1'b1;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_strobes"}, strobes, 1);
    if (!we) checkOutput({tag, "_rdata"}, isDbg ? dbgRdata : cpuRdata, expRdata);
    cpuReq = 1'b0;
    dbgReq = 1'b0;
    @(negedge clock);
    checkOutput({tag, "_ackPulse"}, isDbg ? dbgAck : cpuAck, 0);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    int ackCount;
    int cpuCount;
    int dbgCount;
    int order [0:3];
    logic done;

    reset = 1'b0;
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
    dbgReq = 0; dbgWe = 0; dbgAddr = 0; dbgWdata = 0; dbgLock = 0;
    cpuReq3 = 0; cpuAddr3 = 0;
    repeat (2) @(negedge clock);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_acks", {cpuAck, dbgAck}, 0);
    checkOutput("rst_strobes", {memRe, memWe}, 0);
    checkOutput("rst_memAddr", memAddr, 0);
    checkOutput("rst_memWdata", memWdata, 0);
    checkOutput("rst_rdata", {cpuRdata, dbgRdata}, 0);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] CPU write and read, RD_LAT=1");
    applyStimulus(1'b0, 1'b1, 12'h0A5, 16'h1234, 16'h0000, 2, "cpuWr");
    applyStimulus(1'b0, 1'b0, 12'h0A5, 16'h0000, 16'h1234, 3, "cpuRd");

    $display("[TB] CPU read, RD_LAT=3");
    cpuReq3 = 1'b1; cpuAddr3 = 12'h0A5;
    lat = 0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      if (cpuAck3) done = 1'b1;
    end
    checkOutput("rdLat3_latency", lat, 5);
    checkOutput("rdLat3_rdata", cpuRdata3, 16'h5AA5);
    cpuReq3 = 1'b0;

    $display("[TB] Debug loads then CPU reads back");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 12'h010 + 12'(i), 16'hA000 + 16'(i * 16'h0111), 16'h0000, 2, "dbgLoad");
    applyStimulus(1'b0, 1'b0, 12'h012, 16'h0000, 16'hA222, 3, "cpuRdLoaded");
    applyStimulus(1'b1, 1'b0, 12'h013, 16'h0000, 16'hA333, 3, "dbgRdLoaded");

    $display("[TB] Round-robin with both requests held from reset");
    reset = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h001;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 12'h002;
    for (int i = 0; i < 4; i++) order[i] = 2;
    @(negedge clock);
    reset = 1'b1;
    ackCount = 0; lat = 0;
    while (ackCount < 4 && lat < 40) begin
      @(negedge clock);
      lat++;
      checkOutput("rr_bothAcks", cpuAck && dbgAck, 0);
      if (cpuAck || dbgAck) begin
        order[ackCount] = dbgAck ? 1 : 0;
        ackCount++;
      end
    end
    checkOutput("rr_grant0", order[0], 0);
    checkOutput("rr_grant1", order[1], 1);
    checkOutput("rr_grant2", order[2], 0);
    checkOutput("rr_grant3", order[3], 1);
    cpuReq = 1'b0; dbgReq = 1'b0;
    @(negedge clock);
    waitIdle("rr");

    $display("[TB] Debug lock blocks CPU grants");
    dbgLock = 1'b1;
    cpuReq = 1'b1; dbgReq = 1'b1;
    cpuCount = 0; dbgCount = 0; lat = 0;
    while (dbgCount < 3 && lat < 40) begin
      @(negedge clock);
      lat++;
      if (cpuAck) cpuCount++;
      if (dbgAck) dbgCount++;
    end
    checkOutput("lock_cpuAcks", cpuCount, 0);
    checkOutput("lock_dbgAcks", dbgCount, 3);
    dbgLock = 1'b0;
    lat = 0; done = 1'b0;
    while (!done && lat < 10) begin
      @(negedge clock);
      lat++;
      if (cpuAck || dbgAck) done = 1'b1;
    end
    checkOutput("unlock_cpuAck", cpuAck, 1);
    checkOutput("unlock_dbgAck", dbgAck, 0);
    checkOutput("unlock_latency", lat, 4);
    cpuReq = 1'b0; dbgReq = 1'b0;
    @(negedge clock);
    waitIdle("unlock");

    $display("[TB] Reset during read wait");
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h0A5;
    @(negedge clock);
    checkOutput("midRst_issueRe", memRe, 1);
    @(negedge clock);
    checkOutput("midRst_inWait", busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("midRst_busy", busy, 0);
    checkOutput("midRst_strobes", {memRe, memWe}, 0);
    checkOutput("midRst_acks", {cpuAck, dbgAck}, 0);
    checkOutput("midRst_owner", owner, 0);
    checkOutput("midRst_memAddr", memAddr, 0);
    checkOutput("midRst_cpuRdata", cpuRdata, 0);
    cpuReq = 1'b0;
    @(negedge clock);
    checkOutput("midRst_noAck", cpuAck, 0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("postRst_noAck", cpuAck, 0);
    applyStimulus(1'b0, 1'b0, 12'h0A5, 16'h0000, 16'h1234, 3, "postRstRd");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
